// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU instruction/data memory-port arbiter.
package mem_arb_pkg;

  // Arbiter sequencing: data access is always served before the fetch.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Widest byte-enable vector supported (DATA_W up to 128 bits).
  localparam int MAX_BE_W = 16;

  // Default byte enables for fetches: every byte lane enabled.
  localparam logic [MAX_BE_W-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Serialises CPU data accesses and instruction fetches onto one memory port.
// Handshake: mem_req_o rises when a transaction starts and stays high with
// stable address/data until mem_ack_i is seen at a clock edge; the CPU is
// held stalled (both readies low) until the single DONE cycle, in which the
// CPU advances and both readies are high.
module cpu_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_rd_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic [DATA_W-1:0]   instr_data_o,
  output logic                instr_ready_o,
  input  logic                data_rd_i,
  input  logic                data_wr_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_ready_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i,
  output logic [31:0]         stall_cnt_o
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] instr_data_q, instr_data_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              ready;
  logic              data_req;
  logic              any_req;

  assign data_req = data_rd_i | data_wr_i;
  assign any_req  = data_req | instr_rd_i;

  // Next state, captured read data, memory-side muxing and stall counting.
  always_comb begin
    state_d      = state_q;
    instr_data_d = instr_data_q;
    data_rdata_d = data_rdata_q;
    ready        = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = instr_addr_i;
    mem_wdata_o  = data_wdata_i;
    mem_be_o     = BE_ALL_ONES[BE_W-1:0];
    case (state_q)
      IDLE: begin
        ready = !any_req;
        if (data_req) begin
          state_d = DATA;
        end else if (instr_rd_i) begin
          state_d = INSTR;
        end
      end
      DATA: begin
        mem_req_o  = 1'b1;
        mem_we_o   = data_wr_i;
        mem_addr_o = data_addr_i;
        mem_be_o   = data_be_i;
        if (mem_ack_i) begin
          // A simultaneous read+write is a write: nothing is captured.
          if (!data_wr_i) begin
            data_rdata_d = mem_rdata_i;
          end
          state_d = instr_rd_i ? INSTR : DONE;
        end
      end
      INSTR: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          instr_data_d = mem_rdata_i;
          state_d      = DONE;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    stall_cnt_d = stall_cnt_q;
    if (any_req && !ready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State and result registers; reset abandons any transaction at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      instr_data_q <= '0;
      data_rdata_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      instr_data_q <= instr_data_d;
      data_rdata_q <= data_rdata_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign instr_ready_o = ready;
  assign data_ready_o  = ready;
  assign instr_data_o  = instr_data_q;
  assign data_rdata_o  = data_rdata_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: a CPU-step driver, a memory responder with
// programmable wait states, and a transaction-level expectation model.
module tb_cpu_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        instr_rd_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic [31:0] instr_data_o;
  logic        instr_ready_o;
  logic        data_rd_i = 1'b0;
  logic        data_wr_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_rdata_o;
  logic        data_ready_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [31:0] stall_cnt_o;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_rd_i(instr_rd_i), .instr_addr_i(instr_addr_i),
    .instr_data_o(instr_data_o), .instr_ready_o(instr_ready_o),
    .data_rd_i(data_rd_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_rdata_o(data_rdata_o), .data_ready_o(data_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_cnt_o(stall_cnt_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Expected architectural state.
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_drdata = '0;
  logic [31:0] exp_idata = '0;

  // Expected memory transactions in order: {is_data, we, addr, wdata, be}.
  logic [69:0] exp_q[$];
  int          wait_q[$];
  logic [31:0] rdat_q[$];

  // Memory responder state.
  logic        mem_busy = 1'b0;
  logic [69:0] mem_cur = '0;
  int          mem_wait = 0;
  logic [31:0] mem_rd = '0;

  // One memory cycle, evaluated at the negedge with DUT outputs settled.
  task automatic mem_cycle();
    logic [68:0] got;
    logic [68:0] want;
    if (mem_req_o) begin
      if (!mem_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req got addr=%h we=%b required no request",
                   mem_addr_o, mem_we_o);
          mem_cur  = {1'b0, mem_we_o, mem_addr_o, 32'h0, mem_be_o};
          mem_wait = 0;
          mem_rd   = '0;
        end else begin
          mem_cur  = exp_q.pop_front();
          mem_wait = wait_q.pop_front();
          mem_rd   = rdat_q.pop_front();
        end
        mem_busy = 1'b1;
      end
      got  = {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};
      want = mem_cur[68:0];
      if (!mem_cur[69]) begin
        got[35:4]  = 32'h0;
        want[35:4] = 32'h0;
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mem_txn got we/addr/wdata/be=%h required %h", got, want);
      end
      checks++;
      if ({instr_ready_o, data_ready_o} !== 2'b00) begin
        errors++;
        $display("FAIL ready_during_req got %b required 00",
                 {instr_ready_o, data_ready_o});
      end
      if (mem_wait == 0) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_rd;
        mem_busy    = 1'b0;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        mem_wait--;
      end
    end else begin
      mem_ack_i   = 1'($urandom_range(0, 1));
      mem_rdata_i = $urandom;
    end
  endtask

  // One CPU step: requests are applied in an IDLE cycle and held to DONE.
  task automatic run_step(input logic d_rd, input logic d_wr, input logic i_rd,
                          input logic [31:0] d_addr, input logic [31:0] i_addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int wd, input int wi,
                          input logic [31:0] rd_d, input logic [31:0] rd_i);
    logic dreq;
    int   total;
    dreq  = d_rd | d_wr;
    total = 2 + (dreq ? 1 + wd : 0) + (i_rd ? 1 + wi : 0);
    if (dreq) begin
      exp_q.push_back({1'b1, d_wr, d_addr, wdata, be});
      wait_q.push_back(wd);
      rdat_q.push_back(rd_d);
    end
    if (i_rd) begin
      exp_q.push_back({1'b0, 1'b0, i_addr, 32'h0, 4'hF});
      wait_q.push_back(wi);
      rdat_q.push_back(rd_i);
    end
    @(negedge clk_i);
    data_rd_i    = d_rd;
    data_wr_i    = d_wr;
    instr_rd_i   = i_rd;
    data_addr_i  = d_addr;
    instr_addr_i = i_addr;
    data_wdata_i = wdata;
    data_be_i    = be;
    #1;
    mem_cycle();
    checks++;
    if ({instr_ready_o, data_ready_o} !== {2{!(dreq | i_rd)}}) begin
      errors++;
      $display("FAIL idle_ready got %b required %b",
               {instr_ready_o, data_ready_o}, {2{!(dreq | i_rd)}});
    end
    checks++;
    if (stall_cnt_o !== exp_stall) begin
      errors++;
      $display("FAIL idle_stall got %0d required %0d", stall_cnt_o, exp_stall);
    end
    if (!dreq && !i_rd) return;
    for (int n = 2; n <= total; n++) begin
      @(negedge clk_i);
      if (n < total) begin
        mem_cycle();
        checks++;
        if ({instr_ready_o, data_ready_o} !== 2'b00) begin
          errors++;
          $display("FAIL stall_ready cycle %0d got %b required 00", n,
                   {instr_ready_o, data_ready_o});
        end
      end else begin
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        exp_stall = exp_stall + 32'(total - 1);
        if (d_rd && !d_wr) exp_drdata = rd_d;
        if (i_rd) exp_idata = rd_i;
        checks++;
        if ({instr_ready_o, data_ready_o, mem_req_o} !== 3'b110) begin
          errors++;
          $display("FAIL done_cycle %0d got ready/req=%b required 110", n,
                   {instr_ready_o, data_ready_o, mem_req_o});
        end
        checks++;
        if (data_rdata_o !== exp_drdata) begin
          errors++;
          $display("FAIL data_rdata got %h required %h", data_rdata_o, exp_drdata);
        end
        checks++;
        if (instr_data_o !== exp_idata) begin
          errors++;
          $display("FAIL instr_data got %h required %h", instr_data_o, exp_idata);
        end
        checks++;
        if (stall_cnt_o !== exp_stall) begin
          errors++;
          $display("FAIL stall_cnt got %0d required %0d", stall_cnt_o, exp_stall);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL txn_count got %0d pending required 0", exp_q.size());
      exp_q.delete();
      wait_q.delete();
      rdat_q.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({mem_req_o, instr_ready_o, data_ready_o} !== 3'b011 ||
        stall_cnt_o !== 32'h0 || instr_data_o !== 32'h0 || data_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL %s got req/rdy=%b stall=%0d idata=%h drdata=%h required 011 0 0 0",
               tag, {mem_req_o, instr_ready_o, data_ready_o}, stall_cnt_o,
               instr_data_o, data_rdata_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    #12;
    check_reset_values("reset_state");
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_values("after_release");
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 3; i++)
      run_step(1'b0, 1'b0, 1'b1, 32'h0, 32'h10, 32'h0, 4'h0, 0, 0,
               32'h0, 32'h00500093);
  endtask

  task automatic test_load_fetch();
    run_step(1'b1, 1'b0, 1'b1, 32'h200, 32'h14, 32'h0, 4'hF, 0, 0,
             32'hDEADBEEF, 32'h13);
  endtask

  task automatic test_store_fetch();
    run_step(1'b0, 1'b1, 1'b1, 32'h204, 32'h18, 32'h000000AB, 4'b0001, 0, 0,
             32'h5A5A5A5A, 32'h00100073);
    run_step(1'b0, 1'b1, 1'b0, 32'h208, 32'h1C, 32'h12345678, 4'b1100, 0, 0,
             32'hA5A5A5A5, 32'h0);
  endtask

  task automatic test_wait_states();
    run_step(1'b1, 1'b0, 1'b1, 32'h300, 32'h20, 32'h0, 4'hF, 3, 0,
             32'hCAFEF00D, 32'h00A00113);
    run_step(1'b0, 1'b0, 1'b1, 32'h0, 32'h24, 32'h0, 4'h0, 0, 2,
             32'h0, 32'h00B00193);
  endtask

  task automatic test_rd_wr_both();
    run_step(1'b1, 1'b1, 1'b0, 32'h40C, 32'h28, 32'hFEEDFACE, 4'b0110, 1, 0,
             32'h0BADC0DE, 32'h0);
    run_step(1'b1, 1'b1, 1'b1, 32'h410, 32'h2C, 32'h11112222, 4'hF, 0, 1,
             32'h33334444, 32'h55556666);
  endtask

  task automatic test_random();
    logic d_rd, d_wr, i_rd;
    for (int i = 0; i < 40; i++) begin
      d_rd = 1'($urandom_range(0, 1));
      d_wr = 1'($urandom_range(0, 1));
      i_rd = 1'($urandom_range(0, 1));
      run_step(d_rd, d_wr, i_rd, $urandom, $urandom, $urandom,
               4'($urandom_range(0, 15)), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom, $urandom);
    end
    run_step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_instr();
    @(negedge clk_i);
    instr_rd_i   = 1'b1;
    instr_addr_i = 32'h30;
    data_rd_i    = 1'b0;
    data_wr_i    = 1'b0;
    mem_ack_i    = 1'b0;
    @(negedge clk_i);
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h30) begin
      errors++;
      $display("FAIL instr_pending got req=%b addr=%h required 1 00000030",
               mem_req_o, mem_addr_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL async_req_drop got %b required 0", mem_req_o);
    end
    instr_rd_i = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk_i);
    rst_i = 1'b1;
    exp_stall  = '0;
    exp_drdata = '0;
    exp_idata  = '0;
    mem_busy   = 1'b0;
    exp_q.delete();
    wait_q.delete();
    rdat_q.delete();
    @(negedge clk_i);
    check_reset_values("post_mid_reset");
    run_step(1'b0, 1'b0, 1'b1, 32'h0, 32'h34, 32'h0, 4'h0, 0, 0,
             32'h0, 32'h00C00213);
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_load_fetch();
    test_store_fetch();
    test_wait_states();
    test_rd_wr_both();
    test_random();
    test_reset_mid_instr();
    run_step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
